// File: rtl/jtframe_dump_ctrl.sv
// Frame-windowed capture controller: counts frames on vs falling edges and
// opens one programmable capture window per channel once armed.
module jtframe_dump_ctrl #(
    parameter int CW           = 32,
    parameter int LENW         = 16,
    parameter int CHANNELS     = 2,
    parameter bit ARM_ON_DWNLD = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vs,
    input  logic                     dwnld,
    input  logic [CHANNELS*CW-1:0]   start,
    input  logic [CHANNELS*LENW-1:0] len,
    output logic [CW-1:0]            frame_cnt,
    output logic                     armed,
    output logic [CHANNELS-1:0]      dump_en,
    output logic [CHANNELS-1:0]      dump_on,
    output logic [CHANNELS-1:0]      dump_off,
    output logic [CHANNELS-1:0]      done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ON,
        ST_DONE
    } ch_state_t;

    ch_state_t       st  [CHANNELS];
    logic [LENW-1:0] rem [CHANNELS];
    logic            unb [CHANNELS];

    logic          vs_l, dwnld_l;
    logic          vfall, dfall, drise, disarm;
    logic [CW-1:0] fc_n;

    assign vfall  = vs_l & ~vs;
    assign dfall  = dwnld_l & ~dwnld;
    assign drise  = ~dwnld_l & dwnld;
    assign disarm = ARM_ON_DWNLD ? drise : 1'b0;
    assign fc_n   = frame_cnt + CW'(1);

    // NOTE: every register below is assigned with <= so all of them update
    // together on the edge; = here would let later lines see new values.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_l      <= 1'b0;
            dwnld_l   <= 1'b0;
            frame_cnt <= '0;
            armed     <= 1'b0;
            dump_en   <= '0;
            dump_on   <= '0;
            dump_off  <= '0;
            done      <= '0;
            // NOTE: rem/unb are left out of reset on purpose; they are only
            // read in ST_ON and are always loaded on the way into it.
            for (int ch = 0; ch < CHANNELS; ch++) st[ch] <= ST_IDLE;
        end else begin
            vs_l    <= vs;
            dwnld_l <= dwnld;
            if (vfall) frame_cnt <= fc_n;

            if (ARM_ON_DWNLD) begin
                if (drise)      armed <= 1'b0;
                else if (dfall) armed <= 1'b1;
            end else begin
                armed <= 1'b1;
            end

            dump_on  <= '0;
            dump_off <= '0;

            for (int ch = 0; ch < CHANNELS; ch++) begin
                if (disarm) begin
                    // Disarm beats a simultaneous vfall: nothing opens this cycle
                    if (st[ch] == ST_ON) dump_off[ch] <= 1'b1;
                    st[ch]      <= ST_IDLE;
                    dump_en[ch] <= 1'b0;
                    done[ch]    <= 1'b0;
                end else begin
                    case (st[ch])
                        ST_IDLE: if (armed) st[ch] <= ST_WAIT;
                        ST_WAIT: begin
                            if (vfall && fc_n >= start[ch*CW +: CW]) begin
                                st[ch]      <= ST_ON;
                                rem[ch]     <= len[ch*LENW +: LENW];
                                unb[ch]     <= (len[ch*LENW +: LENW] == '0);
                                dump_en[ch] <= 1'b1;
                                dump_on[ch] <= 1'b1;
                            end
                        end
                        ST_ON: begin
                            if (vfall && !unb[ch]) begin
                                if (rem[ch] == LENW'(1)) begin
                                    st[ch]       <= ST_DONE;
                                    dump_en[ch]  <= 1'b0;
                                    dump_off[ch] <= 1'b1;
                                    done[ch]     <= 1'b1;
                                end else begin
                                    rem[ch] <= rem[ch] - LENW'(1);
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
